// File: rtl/img_seq_defs.sv
// Shared definitions for the block sequencer and the imem side.
// State encoding, coordinate widths and block base address.
package img_seq_defs;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_LOAD,
        DRAIN,
        DONE,
        ERR
    } seq_state_e;

    // Width of a block coordinate for an image dimension in pixels.
    function automatic int coord_w(input int pixels);
        return ($clog2(pixels / 4) < 1) ? 1 : $clog2(pixels / 4);
    endfunction

    // Width of a counter able to hold 0..max_val.
    function automatic int cnt_w(input int max_val);
        return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // imem address of the top-left pixel of block (bx, by).
    function automatic logic [31:0] blk_addr(input int img_w,
                                             input int bx,
                                             input int by);
        return 32'(by * 4 * img_w + bx * 4);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Stall watchdog for the block sequencer.
// Counts cycles without progress and flags expiry.
module seq_watchdog
    import img_seq_defs::*;
#(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic progress,
    output logic expired
);

    localparam int CW = cnt_w(TIMEOUT);

    logic [CW-1:0] cnt;

    // Idle-cycle counter, holds once the expiry value is reached.
    always_ff @(posedge clk) begin
        if (rst || clear || progress) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/img_block_sequencer.sv
// Frame-level 4x4 block sequencer for the compression pipeline.
// Raster walk, fetch handshake, in-flight limit and watchdog.
module img_block_sequencer
    import img_seq_defs::*;
#(
    parameter int IMG_W        = 128,
    parameter int IMG_H        = 128,
    parameter int MAX_INFLIGHT = 2,
    parameter int TIMEOUT      = 1_000_000,
    parameter int ADDR_W       = 14
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             go,
    input  logic                             abort,
    output logic                             fetch_start,
    input  logic                             fetch_ack,
    input  logic                             fetch_done,
    output logic [ADDR_W-1:0]                blk_base,
    output logic [coord_w(IMG_W)-1:0]        blk_x,
    output logic [coord_w(IMG_H)-1:0]        blk_y,
    input  logic                             blk_retired,
    input  logic                             sink_done,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             err_timeout,
    output logic [cnt_w(MAX_INFLIGHT)-1:0]   inflight
);

    localparam int XW = coord_w(IMG_W);
    localparam int YW = coord_w(IMG_H);
    localparam int IW = cnt_w(MAX_INFLIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W / 4 - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H / 4 - 1);
    localparam logic [IW-1:0] I_MAX  = IW'(MAX_INFLIGHT);

    seq_state_e    state_q;
    seq_state_e    state_d;
    logic          fetch_start_d;
    logic          frame_done_d;
    logic          err_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;
    logic [IW-1:0] inf_d;
    logic          acc;
    logic          ret;
    logic          wd_clear;
    logic          wd_progress;
    logic          wd_expired;

    // A request is only accepted while it is actually outstanding.
    assign acc = (state_q == WAIT_ACK) && fetch_ack;
    // Retire pulses at zero in-flight are dropped.
    assign ret = blk_retired && (inflight != '0);

    assign wd_progress = fetch_ack | fetch_done | blk_retired | sink_done;
    assign wd_clear    = (state_q == IDLE) || (state_q == ERR);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clear),
        .progress (wd_progress),
        .expired  (wd_expired)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d       = state_q;
        fetch_start_d = fetch_start;
        frame_done_d  = 1'b0;
        err_d         = err_timeout;
        x_d           = blk_x;
        y_d           = blk_y;
        inf_d         = inflight;

        if (acc && !ret) begin
            inf_d = inflight + IW'(1);
        end else if (ret && !acc) begin
            inf_d = inflight - IW'(1);
        end

        unique case (state_q)
            IDLE, ERR: begin
                if (go) begin
                    state_d = ISSUE;
                    err_d   = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    inf_d   = '0;
                end
            end
            ISSUE: begin
                if (inflight < I_MAX) begin
                    fetch_start_d = 1'b1;
                    state_d       = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (fetch_ack) begin
                    fetch_start_d = 1'b0;
                    state_d       = WAIT_LOAD;
                end
            end
            WAIT_LOAD: begin
                if (fetch_done) begin
                    if (blk_x == X_LAST && blk_y == Y_LAST) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                        if (blk_x == X_LAST) begin
                            x_d = '0;
                            y_d = blk_y + YW'(1);
                        end else begin
                            x_d = blk_x + XW'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (inflight == '0 && sink_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (frame_done) begin
                    state_d = IDLE;
                end else begin
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wd_expired && !wd_progress &&
            state_q inside {ISSUE, WAIT_ACK, WAIT_LOAD, DRAIN}) begin
            state_d       = ERR;
            fetch_start_d = 1'b0;
            err_d         = 1'b1;
        end

        if (abort) begin
            state_d       = IDLE;
            fetch_start_d = 1'b0;
            frame_done_d  = 1'b0;
            err_d         = 1'b0;
            x_d           = '0;
            y_d           = '0;
            inf_d         = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_start <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
            blk_x       <= '0;
            blk_y       <= '0;
            blk_base    <= '0;
            inflight    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_start <= fetch_start_d;
            frame_done  <= frame_done_d;
            err_timeout <= err_d;
            busy        <= (state_d != IDLE);
            blk_x       <= x_d;
            blk_y       <= y_d;
            blk_base    <= ADDR_W'(blk_addr(IMG_W, int'(x_d), int'(y_d)));
            inflight    <= inf_d;
        end
    end

endmodule

// File: tb/tb_img_block_sequencer.sv
// Randomized bench for img_block_sequencer on an 8x8 image.
// Behavioural fetch/retire/sink environment with a scoreboard.
`timescale 1ns/1ps
module tb_img_block_sequencer;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int MAXI = 2;
    localparam int TO   = 100;
    localparam int AW   = 14;
    localparam int BW   = W / 4;
    localparam int NB   = (W / 4) * (H / 4);

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic          abort;
    logic          fetch_start;
    logic          fetch_ack;
    logic          fetch_done;
    logic [AW-1:0] blk_base;
    logic [0:0]    blk_x;
    logic [0:0]    blk_y;
    logic          blk_retired;
    logic          sink_done;
    logic          busy;
    logic          frame_done;
    logic          err_timeout;
    logic [1:0]    inflight;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    img_block_sequencer #(
        .IMG_W        (W),
        .IMG_H        (H),
        .MAX_INFLIGHT (MAXI),
        .TIMEOUT      (TO),
        .ADDR_W       (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .abort       (abort),
        .fetch_start (fetch_start),
        .fetch_ack   (fetch_ack),
        .fetch_done  (fetch_done),
        .blk_base    (blk_base),
        .blk_x       (blk_x),
        .blk_y       (blk_y),
        .blk_retired (blk_retired),
        .sink_done   (sink_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .inflight    (inflight)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr_in();
        rst         = 1'b0;
        go          = 1'b0;
        abort       = 1'b0;
        fetch_ack   = 1'b0;
        fetch_done  = 1'b0;
        blk_retired = 1'b0;
        sink_done   = 1'b0;
    endtask

    // Raster-order address of block i.
    function automatic int exp_base(input int i);
        return ((i / BW) * 4 * W + (i % BW) * 4) % (1 << AW);
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_fs"}, int'(fetch_start), 0);
        chk({tag, "_base"}, int'(blk_base), 0);
        chk({tag, "_bx"}, int'(blk_x), 0);
        chk({tag, "_by"}, int'(blk_y), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_fd"}, int'(frame_done), 0);
        chk({tag, "_err"}, int'(err_timeout), 0);
        chk({tag, "_inf"}, int'(inflight), 0);
    endtask

    task automatic wait_fs(input string tag);
        for (int i = 0; i < 20 && !fetch_start; i++) step();
        chk({tag, "_fs"}, int'(fetch_start), 1);
    endtask

    task automatic run_frame(input int ack_d, input int done_d,
                             input int ret_d, input bit rnd,
                             input int abort_blk, input bit rst_drain);
        int req_n, acc_n, done_n, ret_n, model_inf;
        int ack_cd, done_cd, go_cyc, done_cyc, sink_cyc, spent;
        int ret_q[$];
        bit fs_prev, ack_hold, sink_sent, fin, did_abort, did_rst;
        req_n = 0; acc_n = 0; done_n = 0; ret_n = 0; model_inf = 0;
        ack_cd = -1; done_cd = 0; done_cyc = 0; sink_cyc = 0; spent = 0;
        ack_hold = 0; sink_sent = 0; fin = 0;
        clr_in();
        go = 1'b1;
        go_cyc = cyc;
        step();
        go = 1'b0;
        chk("go_busy", int'(busy), 1);
        fs_prev = fetch_start;
        while (!fin) begin
            if (fetch_start && !fs_prev) begin
                chk("base", int'(blk_base), exp_base(req_n));
                chk("bx", int'(blk_x), req_n % BW);
                chk("by", int'(blk_y), req_n / BW);
                chk("gate", int'(model_inf < MAXI), 1);
                if (req_n == 0) chk("fs_lat", cyc - go_cyc, 2);
                else chk("fs_gap", int'(cyc - done_cyc >= 2), 1);
                req_n++;
                ack_cd = rnd ? int'($urandom_range(ack_d)) : ack_d;
            end
            fs_prev = fetch_start;
            clr_in();
            did_abort = 0;
            did_rst = 0;
            if (abort_blk >= 0 && acc_n == abort_blk + 1 && done_cd > 1) begin
                abort = 1'b1;
                did_abort = 1;
            end else if (rst_drain && done_n == NB && cyc == done_cyc + 2) begin
                rst = 1'b1;
                did_rst = 1;
            end else begin
                if (done_cd > 0) begin
                    done_cd--;
                    if (done_cd == 0) begin
                        fetch_done = 1'b1;
                        done_cyc = cyc;
                        done_n++;
                        ret_q.push_back(cyc + (rnd ? int'($urandom_range(ret_d)) : ret_d));
                    end
                end
                if (ack_hold) begin
                    fetch_ack = 1'b1;
                    ack_hold = 0;
                end else if (ack_cd == 0) begin
                    fetch_ack = 1'b1;
                    ack_cd = -1;
                    done_cd = rnd ? int'($urandom_range(done_d, 1)) : done_d;
                    ack_hold = rnd && ($urandom_range(1) == 1);
                end else if (ack_cd > 0) begin
                    ack_cd--;
                end
                if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
                    blk_retired = 1'b1;
                    void'(ret_q.pop_front());
                    ret_n++;
                end
                if (ret_n == NB && !sink_sent && !blk_retired) begin
                    sink_done = 1'b1;
                    sink_sent = 1;
                    sink_cyc = cyc;
                end
                if (rnd && busy && $urandom_range(7) == 0) go = 1'b1;
            end
            step();
            spent++;
            if (fetch_ack && fs_prev) begin
                acc_n++;
                model_inf++;
            end
            if (blk_retired && model_inf > 0) model_inf--;
            if (did_abort) begin
                chk("ab_busy", int'(busy), 0);
                chk("ab_inf", int'(inflight), 0);
                chk("ab_fs", int'(fetch_start), 0);
                fin = 1;
            end else if (did_rst) begin
                chk_reset_vals("drain_rst");
                fin = 1;
            end else begin
                chk("inflight", int'(inflight), model_inf);
                if (frame_done) begin
                    chk("fd_lat", cyc - sink_cyc, 2);
                    chk("fd_busy", int'(busy), 1);
                    clr_in();
                    step();
                    chk("fd_pulse", int'(frame_done), 0);
                    chk("end_busy", int'(busy), 0);
                    chk("n_req", req_n, NB);
                    chk("n_acc", acc_n, NB);
                    fin = 1;
                end else if (spent > 3000) begin
                    chk("budget", 0, 1);
                    fin = 1;
                end
            end
        end
        clr_in();
    endtask

    initial begin
        int gc;
        int fds;
        clr_in();
        rst = 1'b1;
        step();
        step();
        chk_reset_vals("por");
        rst = 1'b0;
        step();

        run_frame(1, 3, 5, 0, -1, 0);
        for (int k = 0; k < 3; k++) run_frame(3, 4, 8, 1, -1, 0);
        run_frame(0, 1, 50, 0, -1, 0);

        go = 1'b1;
        step();
        go = 1'b0;
        wait_fs("ar0");
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        chk("ar_inf1", int'(inflight), 1);
        fetch_done = 1'b1;
        step();
        fetch_done = 1'b0;
        wait_fs("ar1");
        fetch_ack = 1'b1;
        blk_retired = 1'b1;
        step();
        clr_in();
        chk("ar_inf_same", int'(inflight), 1);
        chk("ar_fs_drop", int'(fetch_start), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ar_ab_inf", int'(inflight), 0);
        chk("ar_ab_busy", int'(busy), 0);

        go = 1'b1;
        gc = cyc;
        step();
        go = 1'b0;
        for (int i = 0; i < TO + 20 && !err_timeout; i++) step();
        chk("to_err", int'(err_timeout), 1);
        chk("to_lat", int'(cyc - gc >= TO - 2 && cyc - gc <= TO + 3), 1);
        chk("to_fs", int'(fetch_start), 0);
        repeat (3) step();
        chk("to_sticky", int'(err_timeout), 1);
        go = 1'b1;
        step();
        go = 1'b0;
        chk("to_clr", int'(err_timeout), 0);
        chk("to_busy", int'(busy), 1);
        wait_fs("to_re");
        chk("to_base", int'(blk_base), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;

        run_frame(1, 3, 5, 0, 1, 0);
        fds = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (frame_done) fds++;
        end
        chk("ab_nofd", fds, 0);
        run_frame(1, 3, 5, 0, -1, 0);

        run_frame(1, 2, 10, 0, -1, 1);
        step();
        run_frame(2, 2, 4, 1, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
